profile_gen_mc: RTL and testbench
=================================

Name: profile_gen_mc

Overview:
- Parametrised successor of the 8-channel, 64-bit profile generator. Supports CHANNELS and WIDTH, per-channel velocity saturation, per-channel speed strobes, abort-complete pulses and step-overrun detection.
- On each acc_step it walks every channel sequentially through a shared register RAM: integrates JJ→J→A→V, clamps at the target or V_MAX, and publishes the effective (average) speed to the step generators.
- The host reads and writes the per-channel registers through a 32-bit lo/hi parameter port.

Parameters:
- CHANNELS, 8, number of motion channels (1..16).
- CH_AW, 3, channel address bits; must satisfy 2**CH_AW >= CHANNELS.
- WIDTH, 64, datapath and register width (33..64). lo half = [31:0], hi half = [WIDTH-1:32].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- acc_step  in  1  one-cycle pulse that starts an update sweep.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep finishes.
- overrun  out  1  one-cycle pulse when acc_step arrives while busy.
- speed  out  CHANNELS*WIDTH  packed signed V_EFF per channel; channel k occupies [k*WIDTH +: WIDTH].
- speed_stb  out  CHANNELS  one-cycle pulse, bit k, when speed of channel k updates.
- param_addr  in  CH_AW+4  host address {channel, reg[3:0]}.
- param_in  in  32  host write data.
- param_write_lo  in  1  write param_in to bits [31:0] of param_addr.
- param_write_hi  in  1  write param_in[WIDTH-33:0] to bits [WIDTH-1:32] of param_addr.
- param_out  out  WIDTH  registered-address read of param_addr; valid 1 cycle after the address is presented.
- abort  in  CHANNELS  per-channel abort request pulse.
- abort_done  out  CHANNELS  one-cycle pulse when a channel's abort reaches V=0.

Behaviour:
- Register map (per channel, reg index):
  - 0 STATUS: b0 enable; b1 target_v_set; b2 abort_active (hw); b3 at_target (hw); b4 saturated (hw).
  - 1 V_EFF, 2 V_IN, 3 V_OUT, 4 A, 5 J, 6 JJ, 7 TARGET_V, 8 ABORT_A, 9 V_MAX (0 = no clamp).
  - Regs 10..15 read as written and are unused.
  - All registers are signed two's complement WIDTH bits.
- RAM: dual-port, host port A / engine port B.
  - A host write and an engine write to the same address in the same cycle: the engine wins.
  - Host lo and hi writes in the same cycle both apply.
  - RAM is not reset; firmware writes STATUS=0 on every channel before the first acc_step.
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, overrun=0, speed=0, speed_stb=0, abort_done=0.
  - pending/abort_active tracking cleared.
- IDLE: on acc_step → busy=1, channel=0, read STATUS.
- acc_step while busy: ignored, overrun pulses for 1 cycle, the sweep continues unaffected.
- Per channel, with STATUS read:
  - enable=0 → skip to the next channel; speed[k] holds and there is no strobe.
  - Pending abort and not abort_active → ABORT sequence, then re-enter this channel's update in the same sweep.
  - Otherwise → UPDATE.
- UPDATE:
  - J'=J+JJ; A'=A+J'; V_IN=V_OUT; Vn=V_OUT+A'.
  - Target clamp: if target_v_set and TARGET_V lies in [min(V_OUT,Vn), max(V_OUT,Vn)] inclusive → Vn=TARGET_V, A=J=JJ=0, STATUS.at_target=1.
  - Saturation: if V_MAX≠0 and |Vn|>V_MAX → Vn=sign(Vn)*V_MAX, A=J=JJ=0, STATUS.saturated=1. The target clamp is applied first.
  - V_OUT=Vn; V_EFF=(V_IN+Vn)>>>1, arithmetic shift computed on the WIDTH+1-bit sum, so there is no overflow.
  - speed[k]=V_EFF and speed_stb[k]=1 in the same cycle V_EFF is written.
  - All additions wrap modulo 2**WIDTH apart from the V_EFF sum.
- ABORT sequence:
  - JJ=J=0; TARGET_V=0; STATUS |= target_v_set|abort_active.
  - A = ABORT_A==0 ? -V_OUT : (V_OUT>0 ? -|ABORT_A| : +|ABORT_A|).
  - V_OUT==0 at abort → abort completes immediately: abort_done pulse, abort_active cleared, no motion.
- Abort completion: when UPDATE clamps to target 0 with abort_active=1 → clear abort_active, clear pending[k], pulse abort_done[k].
- Abort pulses while pending or active are absorbed (no second sequence).
- An abort on a disabled channel stays pending until the channel is enabled.
- Sweep end: after channel CHANNELS-1 → IDLE, busy=0, done=1 for exactly 1 cycle.
- Worst-case sweep length ≤ 32*CHANNELS+2 cycles.
- Reset mid-sweep: outputs go to reset values immediately. RAM contents may hold a partially updated channel.

Test Plan:
- Reset then STATUS=1 (ch0), JJ=0, J=0, A=10, V_OUT=0; one acc_step → V_OUT=10, V_EFF=5, speed_stb[0] pulse, done after busy falls.
- JJ=1, J=0, A=0, V=0, 3 steps → J=3, A=6, V_OUT=10, V_EFF=(4+10)>>>1=7.
- target_v_set, TARGET_V=25, A=10, V=20 → V_OUT=25, A=J=JJ=0, at_target=1; a further step keeps V=25.
- V_MAX=100, V=-95, A=-10 → V_OUT=-100, saturated=1; V_EFF=-98 (from (-95-100)>>>1 = -98).
- V=50, ABORT_A=20, abort[2] pulse → A=-20; after 3 steps V=0, single abort_done[2] pulse; re-pulsing abort mid-ramp has no effect.
- acc_step at busy+1 → overrun pulse; CHANNELS=3, WIDTH=40 build gives identical results for the first two cases.

Source files
------------

// File: rtl/profile_gen_mc.sv
// profile_gen_mc: multi-channel jerk/accel/velocity profile generator sharing one register RAM
module profile_gen_mc #(
  parameter int CHANNELS = 8,
  parameter int CH_AW    = 3,
  parameter int WIDTH    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_acc_step,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_overrun,
  output logic [CHANNELS*WIDTH-1:0]   o_speed,
  output logic [CHANNELS-1:0]         o_speed_stb,
  input  logic [CH_AW+3:0]            i_param_addr,
  input  logic [31:0]                 i_param_in,
  input  logic                        i_param_write_lo,
  input  logic                        i_param_write_hi,
  output logic [WIDTH-1:0]            o_param_out,
  input  logic [CHANNELS-1:0]         i_abort,
  output logic [CHANNELS-1:0]         o_abort_done
);
  localparam int AW = CH_AW + 4;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHK, S_ABRT, S_UPD, S_WB} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_mem [2**AW];
  logic [WIDTH-1:0] r_loc [10];
  logic [AW-1:0] r_raddr, w_baddr;
  logic [CH_AW-1:0] r_ch;
  logic [3:0] r_idx;
  logic [CHANNELS-1:0] r_pending, w_ch_oh, w_clr;
  logic w_adv, w_last, w_we, w_hit, w_sat, w_fin;
  logic [WIDTH-1:0] w_rd, w_veff;
  logic signed [WIDTH-1:0] w_st, w_vout, w_a, w_j, w_jj, w_tv, w_aa, w_vmax;
  logic signed [WIDTH-1:0] w_jn, w_an, w_vn0, w_vn1, w_vn2, w_lo, w_hi, w_aa_abs, w_a_abrt;
  logic signed [WIDTH:0] w_vn1x, w_vmx, w_mag, w_voutx, w_vn2x, w_sum;
  assign w_baddr     = {r_ch, r_idx};
  assign w_rd        = r_mem[w_baddr];
  assign o_param_out = r_mem[r_raddr];
  assign w_ch_oh     = CHANNELS'(1) << r_ch;
  assign w_last      = r_ch == CH_AW'(CHANNELS - 1);
  assign o_busy      = r_state != S_IDLE;
  assign w_st   = r_loc[0];
  assign w_vout = r_loc[3];
  assign w_a    = r_loc[4];
  assign w_j    = r_loc[5];
  assign w_jj   = r_loc[6];
  assign w_tv   = r_loc[7];
  assign w_aa   = r_loc[8];
  assign w_vmax = r_loc[9];
  assign w_jn   = w_j + w_jj;
  assign w_an   = w_a + w_jn;
  assign w_vn0  = w_vout + w_an;
  assign w_lo   = w_vout < w_vn0 ? w_vout : w_vn0;
  assign w_hi   = w_vout < w_vn0 ? w_vn0 : w_vout;
  assign w_hit  = w_st[1] && w_tv >= w_lo && w_tv <= w_hi;
  assign w_vn1  = w_hit ? w_tv : w_vn0;
  assign w_vn1x = {w_vn1[WIDTH-1], w_vn1};
  assign w_vmx  = {w_vmax[WIDTH-1], w_vmax};
  assign w_mag  = w_vn1[WIDTH-1] ? -w_vn1x : w_vn1x;
  assign w_sat  = w_vmax != '0 && w_mag > w_vmx;
  assign w_vn2  = w_sat ? (w_vn1[WIDTH-1] ? -w_vmax : w_vmax) : w_vn1;
  assign w_voutx = {w_vout[WIDTH-1], w_vout};
  assign w_vn2x  = {w_vn2[WIDTH-1], w_vn2};
  assign w_sum   = w_voutx + w_vn2x;
  assign w_veff  = WIDTH'(w_sum >>> 1);
  assign w_fin   = w_hit && w_st[2] && w_tv == '0;
  assign w_aa_abs = w_aa[WIDTH-1] ? -w_aa : w_aa;
  assign w_a_abrt = w_vout == '0 ? '0 : w_aa == '0 ? -w_vout : w_vout > 0 ? -w_aa_abs : w_aa_abs;
  // sweep state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state, RAM write enable, channel advance and abort completion decode
  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    w_we   = 1'b0;
    w_clr  = '0;
    case (r_state)
      S_IDLE: w_next = i_acc_step ? S_LOAD : S_IDLE;
      S_LOAD: w_next = r_idx == 4'd9 ? S_CHK : S_LOAD;
      S_CHK: begin
        w_adv  = !w_st[0];
        w_next = !w_st[0] ? (w_last ? S_IDLE : S_LOAD) : (|(r_pending & w_ch_oh) && !w_st[2]) ? S_ABRT : S_UPD;
      end
      S_ABRT: begin
        w_clr  = w_vout == '0 ? w_ch_oh : '0;
        w_next = S_UPD;
      end
      S_UPD: begin
        w_clr  = w_fin ? w_ch_oh : '0;
        w_next = S_WB;
      end
      S_WB: begin
        w_we   = 1'b1;
        w_adv  = r_idx == 4'd7;
        w_next = r_idx == 4'd7 ? (w_last ? S_IDLE : S_LOAD) : S_WB;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // register RAM: host lo/hi writes, engine write last so it wins on a collision
  always_ff @(posedge clk) begin
    if (i_param_write_lo) r_mem[i_param_addr][31:0] <= i_param_in;
    if (i_param_write_hi) r_mem[i_param_addr][WIDTH-1:32] <= i_param_in[WIDTH-33:0];
    if (w_we) r_mem[w_baddr] <= r_loc[r_idx];
  end
  // channel working copy: load from RAM, apply abort setup, then integrate and clamp
  always_ff @(posedge clk)
    if (r_state == S_LOAD) r_loc[r_idx] <= w_rd;
    else if (r_state == S_ABRT) begin
      r_loc[0] <= {w_st[WIDTH-1:3], w_vout != '0, 1'b1, w_st[0]};
      r_loc[4] <= w_a_abrt;
      r_loc[5] <= '0;
      r_loc[6] <= '0;
      r_loc[7] <= '0;
    end else if (r_state == S_UPD) begin
      r_loc[0] <= {w_st[WIDTH-1:5], w_sat, w_hit, w_st[2] & ~w_fin, w_st[1:0]};
      r_loc[1] <= w_veff;
      r_loc[2] <= w_vout;
      r_loc[3] <= w_vn2;
      r_loc[4] <= (w_hit || w_sat) ? '0 : w_an;
      r_loc[5] <= (w_hit || w_sat) ? '0 : w_jn;
      r_loc[6] <= (w_hit || w_sat) ? '0 : w_jj;
    end
  // sequencing counters, abort tracking and output pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ch         <= '0;
      r_idx        <= '0;
      r_pending    <= '0;
      r_raddr      <= '0;
      o_done       <= 1'b0;
      o_overrun    <= 1'b0;
      o_speed      <= '0;
      o_speed_stb  <= '0;
      o_abort_done <= '0;
    end else begin
      r_raddr      <= i_param_addr;
      r_ch         <= w_adv ? (w_last ? '0 : r_ch + 1'b1) : r_ch;
      r_idx        <= ((r_state == S_LOAD && r_idx == 4'd9) || r_state == S_UPD || w_adv) ? 4'd0 :
                      (r_state == S_LOAD || r_state == S_WB) ? r_idx + 4'd1 : r_idx;
      r_pending    <= (r_pending | i_abort) & ~w_clr;
      o_abort_done <= w_clr;
      o_done       <= w_adv && w_last;
      o_overrun    <= i_acc_step && r_state != S_IDLE;
      o_speed_stb  <= (w_we && r_idx == 4'd1) ? w_ch_oh : '0;
      for (int k = 0; k < CHANNELS; k++)
        if (w_we && r_idx == 4'd1 && w_ch_oh[k]) o_speed[k*WIDTH +: WIDTH] <= r_loc[1];
    end
endmodule

// File: tb/tb_profile_gen_mc.sv
// tb_profile_gen_mc: scoreboard bench for profile_gen_mc
module tb_profile_gen_mc;
  localparam int CH = 8;
  localparam int AW = 3;
  localparam int W  = 64;
  localparam int LIM = 32 * CH + 2;
  typedef struct {int ch; logic [W-1:0] val;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, i_acc_step = 1'b0;
  logic o_busy, o_done, o_overrun;
  logic [CH*W-1:0] o_speed;
  logic [CH-1:0] o_speed_stb, i_abort = '0, o_abort_done;
  logic [AW+3:0] i_param_addr = '0;
  logic [31:0] i_param_in = '0;
  logic i_param_write_lo = 1'b0, i_param_write_hi = 1'b0;
  logic [W-1:0] o_param_out;
  exp_t sb[$];
  exp_t m_e;
  int n_cmp = 0, n_err = 0;
  int adone[CH];
  profile_gen_mc #(.CHANNELS(CH), .CH_AW(AW), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_acc_step(i_acc_step), .o_busy(o_busy), .o_done(o_done),
    .o_overrun(o_overrun), .o_speed(o_speed), .o_speed_stb(o_speed_stb),
    .i_param_addr(i_param_addr), .i_param_in(i_param_in), .i_param_write_lo(i_param_write_lo),
    .i_param_write_hi(i_param_write_hi), .o_param_out(o_param_out), .i_abort(i_abort),
    .o_abort_done(o_abort_done));
  always #5 clk = ~clk;
  // speed strobe scoreboard and abort_done counters
  always @(negedge clk)
    if (rst_n)
      for (int k = 0; k < CH; k++) begin
        if (o_abort_done[k]) adone[k]++;
        if (o_speed_stb[k]) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected ch=%0d got=%0d required=none", k, $signed(o_speed[k*W +: W]));
          end else begin
            m_e = sb.pop_front();
            if (m_e.ch !== k || o_speed[k*W +: W] !== m_e.val) begin
              n_err++;
              $display("FAIL sb_speed ch=%0d got=%0d required ch=%0d val=%0d", k,
                       $signed(o_speed[k*W +: W]), m_e.ch, $signed(m_e.val));
            end
          end
        end
      end
  function automatic logic [W-1:0] sv(input longint x);
    return W'(x);
  endfunction
  function automatic exp_t ex(input int ch, input longint v);
    exp_t e;
    e.ch = ch;
    e.val = sv(v);
    return e;
  endfunction
  task automatic wr(input int ch, input int r, input logic [W-1:0] v);
    @(negedge clk);
    i_param_addr = {AW'(ch), 4'(r)};
    i_param_in = v[31:0];
    i_param_write_lo = 1'b1;
    @(negedge clk);
    i_param_write_lo = 1'b0;
    i_param_write_hi = 1'b1;
    i_param_in = 32'(v >> 32);
    @(negedge clk);
    i_param_write_hi = 1'b0;
  endtask
  task automatic rd(input int ch, input int r, output logic [W-1:0] v);
    @(negedge clk);
    i_param_addr = {AW'(ch), 4'(r)};
    @(negedge clk);
    v = o_param_out;
  endtask
  task automatic step(output logic busy_at_done);
    int cyc;
    @(negedge clk);
    i_acc_step = 1'b1;
    @(negedge clk);
    i_acc_step = 1'b0;
    cyc = 1;
    while (!o_done && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    busy_at_done = o_busy;
    n_cmp++;
    if (!o_done) begin
      n_err++;
      $display("FAIL step_timeout cycles=%0d required<=%0d", cyc, LIM);
    end
  endtask
  task automatic pulse_abort(input int ch);
    @(negedge clk);
    i_abort[ch] = 1'b1;
    @(negedge clk);
    i_abort = '0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b required=0", o_busy); end
    if (o_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b required=0", o_done); end
    if (o_overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got=%b required=0", o_overrun); end
    if (o_speed !== '0) begin n_err++; $display("FAIL rst_speed got=%h required=0", o_speed); end
    if (o_speed_stb !== '0) begin n_err++; $display("FAIL rst_stb got=%b required=0", o_speed_stb); end
    if (o_abort_done !== '0) begin n_err++; $display("FAIL rst_adone got=%b required=0", o_abort_done); end
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 16; r++) wr(c, r, '0);
  endtask
  task automatic test_basic;
    logic b;
    logic [W-1:0] v;
    wr(0, 4, sv(10));
    wr(0, 0, sv(1));
    sb.push_back(ex(0, 5));
    step(b);
    n_cmp += 4;
    if (b !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got=%b required=0", b); end
    if (o_speed[0 +: W] !== sv(5)) begin n_err++; $display("FAIL basic_speed got=%0d required=5", $signed(o_speed[0 +: W])); end
    rd(0, 3, v);
    if (v !== sv(10)) begin n_err++; $display("FAIL basic_vout got=%0d required=10", $signed(v)); end
    rd(0, 1, v);
    if (v !== sv(5)) begin n_err++; $display("FAIL basic_veff got=%0d required=5", $signed(v)); end
    wr(0, 0, '0);
  endtask
  task automatic test_jerk;
    logic b;
    logic [W-1:0] v;
    wr(1, 6, sv(1));
    wr(1, 0, sv(1));
    sb.push_back(ex(1, 0));
    sb.push_back(ex(1, 2));
    sb.push_back(ex(1, 7));
    repeat (3) step(b);
    n_cmp += 3;
    rd(1, 5, v);
    if (v !== sv(3)) begin n_err++; $display("FAIL jerk_j got=%0d required=3", $signed(v)); end
    rd(1, 4, v);
    if (v !== sv(6)) begin n_err++; $display("FAIL jerk_a got=%0d required=6", $signed(v)); end
    rd(1, 3, v);
    if (v !== sv(10)) begin n_err++; $display("FAIL jerk_vout got=%0d required=10", $signed(v)); end
    wr(1, 0, '0);
  endtask
  task automatic test_target;
    logic b;
    logic [W-1:0] v;
    wr(3, 7, sv(25));
    wr(3, 4, sv(10));
    wr(3, 3, sv(20));
    wr(3, 0, sv(3));
    sb.push_back(ex(3, 22));
    step(b);
    n_cmp += 4;
    rd(3, 3, v);
    if (v !== sv(25)) begin n_err++; $display("FAIL tgt_vout got=%0d required=25", $signed(v)); end
    rd(3, 4, v);
    if (v !== '0) begin n_err++; $display("FAIL tgt_a got=%0d required=0", $signed(v)); end
    rd(3, 0, v);
    if (v !== sv(11)) begin n_err++; $display("FAIL tgt_status got=%0d required=11", v); end
    sb.push_back(ex(3, 25));
    step(b);
    rd(3, 3, v);
    if (v !== sv(25)) begin n_err++; $display("FAIL tgt_hold got=%0d required=25", $signed(v)); end
    wr(3, 0, '0);
  endtask
  task automatic test_saturate;
    logic b;
    logic [W-1:0] v;
    wr(4, 9, sv(100));
    wr(4, 3, sv(-95));
    wr(4, 4, sv(-10));
    wr(4, 0, sv(1));
    sb.push_back(ex(4, -98));
    step(b);
    n_cmp += 3;
    rd(4, 3, v);
    if (v !== sv(-100)) begin n_err++; $display("FAIL sat_vout got=%0d required=-100", $signed(v)); end
    rd(4, 0, v);
    if (v !== sv(17)) begin n_err++; $display("FAIL sat_status got=%0d required=17", v); end
    rd(4, 4, v);
    if (v !== '0) begin n_err++; $display("FAIL sat_a got=%0d required=0", $signed(v)); end
    wr(4, 0, '0);
  endtask
  task automatic test_abort;
    logic b;
    logic [W-1:0] v;
    wr(2, 3, sv(50));
    wr(2, 8, sv(20));
    wr(2, 0, sv(1));
    pulse_abort(2);
    sb.push_back(ex(2, 40));
    step(b);
    n_cmp += 7;
    rd(2, 4, v);
    if (v !== sv(-20)) begin n_err++; $display("FAIL abort_a got=%0d required=-20", $signed(v)); end
    rd(2, 0, v);
    if (v !== sv(7)) begin n_err++; $display("FAIL abort_status got=%0d required=7", v); end
    pulse_abort(2);
    sb.push_back(ex(2, 20));
    step(b);
    if (adone[2] !== 0) begin n_err++; $display("FAIL abort_early_done got=%0d required=0", adone[2]); end
    sb.push_back(ex(2, 5));
    step(b);
    if (adone[2] !== 1) begin n_err++; $display("FAIL abort_done_cnt got=%0d required=1", adone[2]); end
    rd(2, 3, v);
    if (v !== '0) begin n_err++; $display("FAIL abort_vout got=%0d required=0", $signed(v)); end
    rd(2, 0, v);
    if (v !== sv(11)) begin n_err++; $display("FAIL abort_status_end got=%0d required=11", v); end
    sb.push_back(ex(2, 0));
    step(b);
    if (adone[2] !== 1) begin n_err++; $display("FAIL abort_extra_done got=%0d required=1", adone[2]); end
    wr(2, 0, '0);
  endtask
  task automatic test_abort_zero;
    logic b;
    logic [W-1:0] v;
    wr(5, 8, sv(20));
    wr(5, 0, sv(1));
    pulse_abort(5);
    sb.push_back(ex(5, 0));
    step(b);
    n_cmp += 3;
    if (adone[5] !== 1) begin n_err++; $display("FAIL azero_done got=%0d required=1", adone[5]); end
    rd(5, 3, v);
    if (v !== '0) begin n_err++; $display("FAIL azero_vout got=%0d required=0", $signed(v)); end
    rd(5, 4, v);
    if (v !== '0) begin n_err++; $display("FAIL azero_a got=%0d required=0", $signed(v)); end
    wr(5, 0, '0);
  endtask
  task automatic test_back_to_back;
    int nd;
    wr(6, 4, sv(2));
    wr(6, 0, sv(1));
    sb.push_back(ex(6, 1));
    @(negedge clk);
    i_acc_step = 1'b1;
    @(negedge clk);
    n_cmp += 4;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b required=1", o_busy); end
    @(negedge clk);
    i_acc_step = 1'b0;
    if (o_overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun got=%b required=1", o_overrun); end
    @(negedge clk);
    if (o_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun_len got=%b required=0", o_overrun); end
    nd = 0;
    for (int i = 0; i < 2 * LIM; i++) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    if (nd !== 1) begin n_err++; $display("FAIL b2b_done_cnt got=%0d required=1", nd); end
    wr(6, 0, '0);
  endtask
  task automatic test_regs;
    logic [W-1:0] v;
    wr(7, 12, 64'h1234_5678_9abc_def0);
    @(negedge clk);
    i_param_addr = {AW'(7), 4'd12};
    i_param_in = 32'h0bad_f00d;
    i_param_write_lo = 1'b1;
    @(negedge clk);
    i_param_write_lo = 1'b0;
    rd(7, 12, v);
    n_cmp += 2;
    if (v !== 64'h1234_5678_0bad_f00d) begin n_err++; $display("FAIL reg_rw got=%h required=12345678_0badf00d", v); end
    if (o_speed[0 +: W] !== sv(5)) begin n_err++; $display("FAIL hold_speed got=%0d required=5", $signed(o_speed[0 +: W])); end
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    i_acc_step = 1'b1;
    @(negedge clk);
    i_acc_step = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b required=1", o_busy); end
    #2 rst_n = 1'b0;
    #1;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b required=0", o_busy); end
    if (o_speed !== '0) begin n_err++; $display("FAIL mid_rst_speed got=%h required=0", o_speed); end
    if (sb.size() !== 0) begin n_err++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_jerk;
    test_target;
    test_saturate;
    test_abort;
    test_abort_zero;
    test_back_to_back;
    test_regs;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
